// File: rtl/rollo_pkg.sv
// rollo_pkg: shared geometry and state encoding for the ROLLO-II ciphertext streamer
package rollo_pkg;
   localparam int N          = 189;
   localparam int M          = 83;
   localparam int DIGIT      = 4;
   localparam int W          = M * DIGIT;
   localparam int WORDS      = (N + DIGIT - 1) / DIGIT;
   localparam int CHUNKS     = (W + 31) / 32;
   localparam int TAG_CHUNKS = 16;
   localparam int LAST_BITS  = W - 32 * (CHUNKS - 1);
   localparam int AW         = $clog2(WORDS);
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_EMIT  = 3'd3;
   localparam logic [2:0] ST_TAG   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;
endpackage

// File: rtl/ct_stream_out_if.sv
// ct_stream_out_if: 32-bit valid/ready output stream with end-of-packet flag
interface ct_stream_out_if;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ct_chunk_shift.sv
// ct_chunk_shift: W-bit word buffer that drains 32 bits at a time, LSB first
module ct_chunk_shift
   import rollo_pkg::*;
(
   input  logic         clk,
   input  logic         rst_b,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic [31:0]  dout
);
   logic [W-1:0] q;
   // load a fresh word, or drop the consumed chunk and zero-fill from the top
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b) q <= '0;
      else if (load) q <= din;
      else if (shift) q <= {32'b0, q[W-1:32]};
   assign dout = q[31:0];
endmodule

// File: rtl/ct_stream_out.sv
// ct_stream_out: streams the ciphertext memory as 32-bit chunks followed by the 512-bit tag
module ct_stream_out
   import rollo_pkg::*;
(
   input  logic          clk,
   input  logic          rst_b,
   input  logic          start,
   input  logic [511:0]  tag,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rw,
   input  logic [W-1:0]  mem_dout,
   ct_stream_out_if.master s,
   output logic          busy,
   output logic          done
);
   localparam logic [3:0]    CI_LAST = 4'(CHUNKS - 1);
   localparam logic [3:0]    TI_LAST = 4'(TAG_CHUNKS - 1);
   localparam logic [AW-1:0] WI_LAST = AW'(WORDS - 1);
   logic [2:0]    state;
   logic [AW-1:0] wi;
   logic [3:0]    ci;
   logic [3:0]    ti;
   logic [511:0]  tag_q;
   logic [31:0]   chunk;
   logic          hs;
   assign hs       = s.out_valid & s.out_ready;
   assign mem_addr = wi;
   assign mem_rw   = 1'b0;
   ct_chunk_shift u_shift (
      .clk   (clk),
      .rst_b (rst_b),
      .load  (state == ST_LOAD),
      .shift (state == ST_EMIT && hs),
      .din   (mem_dout),
      .dout  (chunk)
   );
   // outputs decoded from state and registers only, never from out_ready
   always_comb begin
      s.out_valid = state == ST_EMIT || state == ST_TAG;
      s.out_last  = state == ST_TAG && ti == TI_LAST;
      s.out_data  = state == ST_EMIT ? chunk : state == ST_TAG ? tag_q[{ti, 5'b0} +: 32] : 32'b0;
      busy        = state != ST_IDLE;
      done        = state == ST_DONE;
   end
   // sequencing: word fetch, chunk emission, tag emission; everything holds while stalled
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b) begin
         state <= ST_IDLE;
         wi    <= '0;
         ci    <= '0;
         ti    <= '0;
         tag_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               tag_q <= tag;
               wi    <= '0;
               ti    <= '0;
               state <= ST_FETCH;
            end
            ST_FETCH: state <= ST_LOAD;
            ST_LOAD: begin
               ci    <= '0;
               state <= ST_EMIT;
            end
            ST_EMIT: if (hs) begin
               ci <= ci + 4'd1;
               if (ci == CI_LAST) begin
                  if (wi == WI_LAST) state <= ST_TAG;
                  else begin
                     wi    <= wi + 1'b1;
                     state <= ST_FETCH;
                  end
               end
            end
            ST_TAG: if (hs) begin
               ti <= ti + 4'd1;
               if (ti == TI_LAST) state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_ct_stream_out.sv
// tb_ct_stream_out: ramp, backpressure, ignored-start, abort and tag-only runs against a chunk-order model
module tb_ct_stream_out;
   import rollo_pkg::*;
   localparam int TOTAL = WORDS * CHUNKS + TAG_CHUNKS;
   logic          clk;
   logic          rst_b;
   logic          start;
   logic [511:0]  tag;
   logic [AW-1:0] mem_addr;
   logic          mem_rw;
   logic [W-1:0]  mem_dout;
   logic          busy;
   logic          done;
   logic [W-1:0]  ct_mem [0:63];
   ct_stream_out_if s ();
   ct_stream_out dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .start    (start),
      .tag      (tag),
      .mem_addr (mem_addr),
      .mem_rw   (mem_rw),
      .mem_dout (mem_dout),
      .s        (s),
      .busy     (busy),
      .done     (done)
   );
   typedef struct {
      int         cyc;
      logic       valid;
      logic       last;
      logic       busy;
      logic       done;
      logic [5:0] addr;
   } probe_t;
   probe_t      pt [12];
   logic [31:0] exp_q [$];
   int n_cmp = 0;
   int n_bad = 0;
   int nc = 0;
   int start_nc = 0;
   int hidx = 0;
   int done_cnt = 0;
   int cyc = 0;
   bit mon_en = 0;
   bit tim = 0;
   logic pv = 0, pr = 0, pl = 0;
   logic [31:0] pd = 0;
   initial clk = 0;
   always #5 clk = ~clk;
   // ciphertext RAM with one cycle of read latency
   always @(posedge clk) mem_dout <= ct_mem[mem_addr];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
      end
   endtask
   function automatic int ecyc(input int i);
      return i < WORDS * CHUNKS ? 13 * (i / CHUNKS) + 3 + (i % CHUNKS) : 625 + (i - WORDS * CHUNKS);
   endfunction
   // monitor: chunk order, hold-while-stalled, cycle placement, done pulse
   always @(negedge clk) begin
      nc++;
      if (mon_en) begin
         cyc = nc - start_nc - 1;
         if (tim)
            foreach (pt[i])
               if (pt[i].cyc == cyc) begin
                  chk($sformatf("probe%0d_valid", i), 32'(s.out_valid), 32'(pt[i].valid));
                  chk($sformatf("probe%0d_last", i), 32'(s.out_last), 32'(pt[i].last));
                  chk($sformatf("probe%0d_busy", i), 32'(busy), 32'(pt[i].busy));
                  chk($sformatf("probe%0d_done", i), 32'(done), 32'(pt[i].done));
                  chk($sformatf("probe%0d_addr", i), 32'(mem_addr), 32'(pt[i].addr));
               end
         if (pv && !pr) begin
            chk("hold_valid", 32'(s.out_valid), 32'd1);
            chk("hold_data", s.out_data, pd);
            chk("hold_last", 32'(s.out_last), 32'(pl));
         end
         if (s.out_valid && s.out_ready) begin
            if (hidx >= TOTAL) chk("hs_count", 32'(hidx), 32'(TOTAL - 1));
            else begin
               chk($sformatf("data%0d", hidx), s.out_data, exp_q[hidx]);
               chk($sformatf("last%0d", hidx), 32'(s.out_last), 32'(hidx == TOTAL - 1));
               if (tim) chk($sformatf("hs_cycle%0d", hidx), 32'(cyc), 32'(ecyc(hidx)));
            end
            hidx++;
         end
         if (done) begin
            done_cnt++;
            chk("done_hs", 32'(hidx), 32'(TOTAL));
            if (tim) chk("done_cycle", 32'(cyc), 32'd641);
         end
         chk("mem_rw", 32'(mem_rw), 32'd0);
         pv = s.out_valid;
         pr = s.out_ready;
         pd = s.out_data;
         pl = s.out_last;
      end
   end
   task automatic check_idle_zero(input string name);
      chk({name, "_addr"}, 32'(mem_addr), 32'd0);
      chk({name, "_data"}, s.out_data, 32'd0);
      chk({name, "_valid"}, 32'(s.out_valid), 32'd0);
      chk({name, "_last"}, 32'(s.out_last), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_done"}, 32'(done), 32'd0);
   endtask
   task automatic run(input int pct, input bit timing, input bit extra, input int abort_at, input bit scramble);
      logic [W-1:0] w;
      bit aborted = 0;
      exp_q.delete();
      for (int k = 0; k < WORDS; k++)
         for (int j = 0; j < CHUNKS; j++) begin
            w = ct_mem[k] >> (32 * j);
            exp_q.push_back(w[31:0]);
         end
      for (int t = 0; t < TAG_CHUNKS; t++) exp_q.push_back(tag[32 * t +: 32]);
      hidx = 0;
      done_cnt = 0;
      pv = 0;
      tim = timing;
      @(posedge clk);
      #1;
      start = 1;
      s.out_ready = pct >= 100 ? 1'b1 : 1'($urandom_range(99) < pct);
      start_nc = nc;
      mon_en = 1;
      for (int c = 0; c < 4000 && done_cnt == 0 && !aborted; c++) begin
         @(posedge clk);
         #1;
         start = extra && (c + 1 == 5 || c + 1 == 300);
         if (scramble) tag = {16{$urandom}};
         s.out_ready = pct >= 100 ? 1'b1 : 1'($urandom_range(99) < pct);
         if (abort_at == c + 1) begin
            rst_b = 1;
            mon_en = 0;
            aborted = 1;
         end
      end
      if (aborted) begin
         @(negedge clk);
         check_idle_zero("abort");
         chk("abort_no_done", 32'(done_cnt), 32'd0);
         @(posedge clk);
         #1;
         rst_b = 0;
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk("post_abort_quiet", {29'b0, s.out_valid, busy, done}, 32'd0);
         end
      end else begin
         chk("done_seen", 32'(done_cnt), 32'd1);
         start = 0;
         repeat (20) @(posedge clk);
         @(negedge clk);
         chk("single_done", 32'(done_cnt), 32'd1);
         chk("total_hs", 32'(hidx), 32'(TOTAL));
         chk("idle_busy", 32'(busy), 32'd0);
         mon_en = 0;
      end
   endtask
   task automatic fill_ramp();
      for (int k = 0; k < 64; k++) ct_mem[k] = {DIGIT{83'(k)}};
   endtask
   task automatic fill_random();
      logic [351:0] t;
      for (int k = 0; k < 64; k++) begin
         for (int i = 0; i < 11; i++) t[32 * i +: 32] = $urandom;
         ct_mem[k] = t[W-1:0];
      end
   endtask
   initial begin
      pt[0]  = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
      pt[1]  = '{2,   1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
      pt[2]  = '{3,   1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
      pt[3]  = '{13,  1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
      pt[4]  = '{14,  1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
      pt[5]  = '{15,  1'b0, 1'b0, 1'b1, 1'b0, 6'd1};
      pt[6]  = '{16,  1'b1, 1'b0, 1'b1, 1'b0, 6'd1};
      pt[7]  = '{624, 1'b1, 1'b0, 1'b1, 1'b0, 6'd47};
      pt[8]  = '{625, 1'b1, 1'b0, 1'b1, 1'b0, 6'd47};
      pt[9]  = '{640, 1'b1, 1'b1, 1'b1, 1'b0, 6'd47};
      pt[10] = '{641, 1'b0, 1'b0, 1'b1, 1'b1, 6'd47};
      pt[11] = '{642, 1'b0, 1'b0, 1'b0, 1'b0, 6'd47};
      rst_b = 0;
      start = 0;
      tag = '0;
      s.out_ready = 0;
      #1 rst_b = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_zero("reset");
      @(posedge clk);
      #1 rst_b = 0;
      fill_ramp();
      tag = {8{64'h0123456789abcdef}};
      run(100, 1, 0, 0, 0);
      run(40, 0, 0, 0, 0);
      fill_random();
      tag = {16{$urandom}};
      run(40, 0, 0, 0, 0);
      fill_ramp();
      run(100, 1, 1, 0, 0);
      run(100, 0, 0, 200, 0);
      run(100, 1, 0, 0, 0);
      for (int k = 0; k < 64; k++) ct_mem[k] = '0;
      tag = {16{32'hAAAAAAAA}};
      run(100, 1, 0, 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ct_stream_out.md
# ct_stream_out

Downstream stage of the ROLLO-II encryptor. After the encryptor's done pulse, this block reads the finished ciphertext memory `ct`, one `m*digit`-bit word at a time. It serializes each word into 32-bit chunks, least significant first, and then appends the 512-bit SHA3 tag. The result is streamed on a valid/ready interface toward the host bus.

## Interface
- `n`, 189: code length (ring elements).
- `m`, 83: extension degree.
- `digit`, 4: coefficients per memory word.
- Derived: `W = m*digit` (332); `WORDS = ceil(n/digit)` (48); `CHUNKS = ceil(W/32)` (11); `TAG_CHUNKS = 16`.
- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: reset, asynchronous, active-high (asserted = 1). This is decided.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `tag` in 512: SHA3 output, captured on accepted `start`.
- `mem_addr` out `clog2(WORDS)`: `ct` read address.
- `mem_rw` out 1: tied 0 (read only).
- `mem_dout` in W: `ct` read data, valid one cycle after address.
- `out_data` out 32: stream chunk.
- `out_valid` out 1: chunk valid.
- `out_ready` in 1: sink accepts.
- `out_last` out 1: high with the final tag chunk.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last handshake.

## Operation
- States:
  - IDLE: on `start`, capture `tag`, set word index `wi` = 0, set `mem_addr` = 0 → FETCH.
  - FETCH: wait one cycle for RAM latency → LOAD.
  - LOAD: capture `mem_dout` into the W-bit shift buffer, set chunk index `ci` = 0 → EMIT.
  - EMIT: `out_valid` = 1, `out_data` = `buf[31:0]`.
    - On handshake (`out_valid & out_ready`), shift `buf` right by 32 with zero fill and increment `ci`.
    - On the handshake at `ci == CHUNKS-1`: if `wi == WORDS-1` → TAG; otherwise increment `wi` and `mem_addr` → FETCH.
  - TAG: `out_valid` = 1, `out_data` = `tag[32*ti +: 32]`, starting at `ti` = 0.
    - `out_last` = 1 when `ti == 15`.
    - On the handshake at `ti == 15` → DONE.
  - DONE: `done` = 1 for one cycle → IDLE.
- Last chunk of each word carries `W - 32*(CHUNKS-1)` = 12 data bits, bits [31:12] = 0.
- Data is passed through unmodified; the block adds no XOR or masking.
- `start` asserted while `busy` is ignored; no queuing.
- Total handshakes per run: `WORDS*CHUNKS + 16` = 544.

## Timing
- Reset values: `mem_addr` = 0, `out_data` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0, `done` = 0; state IDLE; buffer, tag register and all counters cleared.
- Reset asserted mid-run aborts immediately, asynchronously. No further handshake completes, and no `done` is issued.
- Cycle counts below assume `start` is sampled at edge 0 and `out_ready` is held at 1:
  - Word k occupies cycles 13k+1 … 13k+13: FETCH, LOAD, then 11 EMIT cycles.
  - First `out_valid` is in cycle 3.
  - Tag chunks occupy cycles 625–640.
  - `done` is in cycle 641.
- `out_valid` drops for exactly 2 cycles between words. It stays high continuously from the last ciphertext chunk into the tag.
- Handshake hold rule: while `out_valid & !out_ready`, `out_data`, `out_last` and all internal state hold. `out_valid` never deasserts without a handshake.
- All outputs are registered or decoded from state/registers only; there is no combinational path from `out_ready` to `out_data`.

## Structure
- Shared package `rollo_pkg`:
  - `W`, `WORDS`, `CHUNKS`, `TAG_CHUNKS`, `LAST_BITS`.
  - Address width `clog2(WORDS)`.
  - State encoding IDLE/FETCH/LOAD/EMIT/TAG/DONE.
- Sub-module `ct_chunk_shift`: W-bit load/shift-right-32 register. Ports: `load`, `shift`, `din`, `dout[31:0]`.
- The FSM, counters and tag mux stay in the top.

## Test plan
- Ramp data: `ct` word k = k replicated across the word, `tag` = 512'h0123…, `out_ready` held at 1. Required response:
  - 544 chunks in the expected order.
  - Chunk 10 of each word has [31:12] = 0.
  - `out_last` only on chunk 544.
  - `done` in cycle 641.
- Random backpressure (`out_ready` ~40% duty) → identical chunk sequence; `out_data` stable across every stall; no drop of `out_valid` mid-word.
- `start` pulsed in cycles 5 and 300 of a run → ignored; exactly one run and one `done`.
- `rst_b` = 1 in cycle 200 → all outputs 0 next sample. A new `start` afterwards restarts from address 0, chunk 0.
- Tag only: `tag` bit i = i[0], i.e. 0xAAAAAAAA words → tag chunks all 32'hAAAAAAAA, with `tag` changed after `start` not affecting output.
